// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges hazard, branch redirect, data-memory wait and trap
// entry into per-stage register modes. Optional perf counters: PIPELINE_CTRL_PERF_EN.
`ifndef Normal
`define Normal 2'b00
`endif
`ifndef Stall
`define Stall 2'b01
`endif
`ifndef Flush
`define Flush 2'b10
`endif
`ifndef Hazard_Signal_Width
`define Hazard_Signal_Width 4
`endif

module pipeline_ctrl #(
  parameter int TRAP_DRAIN = 3,
  parameter int HSW        = `Hazard_Signal_Width
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     hdu_if_id_mode,
  input  logic [1:0]     hdu_id_exe_mode,
  input  logic           hdu_if_stall,
  input  logic [HSW-1:0] hdu_signal_cycle,
  input  logic           exe_redirect,
  input  logic           mem_busy,
  input  logic           trap_req,
  output logic           pc_stall,
  output logic [1:0]     if_id_mode,
  output logic [1:0]     id_exe_mode,
  output logic [1:0]     exe_mem_mode,
  output logic [1:0]     mem_wb_mode,
  output logic           trap_pc_load,
  output logic           ctrl_busy
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_stall_cycles,
  output logic [31:0]    perf_flush_events
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam int CW = (HSW > 4) ? HSW : 4;

  logic [1:0]    state_q, state_d, ret_q, ret_d, eff_state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_redir_q, pend_redir_d, pend_trap_q, pend_trap_d;
  logic [1:0]    lat_if_id_q, lat_if_id_d, lat_id_exe_q, lat_id_exe_d;
  logic          lat_stall_q, lat_stall_d;
  logic          trap_now, redir_now;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    pend_redir_d = pend_redir_q;
    pend_trap_d  = pend_trap_q;
    lat_if_id_d  = lat_if_id_q;
    lat_id_exe_d = lat_id_exe_q;
    lat_stall_d  = lat_stall_q;
    pc_stall     = 1'b0;
    if_id_mode   = `Normal;
    id_exe_mode  = `Normal;
    exe_mem_mode = `Normal;
    mem_wb_mode  = `Normal;
    trap_pc_load = 1'b0;
    ctrl_busy    = (state_q != ST_RUN);
    // Leaving MWAIT resumes the saved state's rules in the same cycle.
    eff_state    = (state_q == ST_MWAIT) ? ret_q : state_q;
    trap_now     = trap_req | pend_trap_q;
    redir_now    = exe_redirect | pend_redir_q;

    if (!rst_n) begin
      ctrl_busy    = 1'b0;
      state_d      = ST_RUN;
      cnt_d        = '0;
      pend_redir_d = 1'b0;
      pend_trap_d  = 1'b0;
    end else if (state_q == ST_DRAIN) begin
      // Pipeline is empty here: mem_busy and new pulses are not looked at.
      if_id_mode   = `Flush;
      id_exe_mode  = `Flush;
      exe_mem_mode = `Flush;
      if (cnt_q == '0) begin
        trap_pc_load = 1'b1;
        state_d      = ST_RUN;
      end else begin
        pc_stall = 1'b1;
        cnt_d    = cnt_q - CW'(1);
      end
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_mode   = `Stall;
      id_exe_mode  = `Stall;
      exe_mem_mode = `Stall;
      mem_wb_mode  = `Flush;
      if (state_q != ST_MWAIT) ret_d = state_q;
      state_d      = ST_MWAIT;
      pend_trap_d  = pend_trap_q | trap_req;
      pend_redir_d = pend_redir_q | exe_redirect;
    end else if (trap_now) begin
      pc_stall     = 1'b1;
      if_id_mode   = `Flush;
      id_exe_mode  = `Flush;
      exe_mem_mode = `Flush;
      cnt_d        = CW'(TRAP_DRAIN - 1);
      pend_trap_d  = 1'b0;
      pend_redir_d = 1'b0;
      state_d      = ST_DRAIN;
    end else if (redir_now) begin
      if_id_mode   = `Flush;
      id_exe_mode  = `Flush;
      pend_redir_d = 1'b0;
      state_d      = ST_RUN;
    end else if (eff_state == ST_HOLD) begin
      pc_stall    = lat_stall_q;
      if_id_mode  = lat_if_id_q;
      id_exe_mode = lat_id_exe_q;
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_HOLD;
        cnt_d   = cnt_q - CW'(1);
      end
    end else begin
      state_d = ST_RUN;
      if (hdu_signal_cycle != '0) begin
        pc_stall    = hdu_if_stall;
        if_id_mode  = hdu_if_id_mode;
        id_exe_mode = hdu_id_exe_mode;
        if (hdu_signal_cycle > HSW'(1)) begin
          lat_if_id_d  = hdu_if_id_mode;
          lat_id_exe_d = hdu_id_exe_mode;
          lat_stall_d  = hdu_if_stall;
          cnt_d        = CW'(hdu_signal_cycle) - CW'(2);
          state_d      = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      ret_q        <= ST_RUN;
      cnt_q        <= '0;
      pend_redir_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      lat_if_id_q  <= `Normal;
      lat_id_exe_q <= `Normal;
      lat_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cnt_q        <= cnt_d;
      pend_redir_q <= pend_redir_d;
      pend_trap_q  <= pend_trap_d;
      lat_if_id_q  <= lat_if_id_d;
      lat_id_exe_q <= lat_id_exe_d;
      lat_stall_q  <= lat_stall_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        prev_flush_q, prev_flush_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, pc_stall};
    flush_cnt_d  = flush_cnt_q + {31'd0, (if_id_mode == `Flush) && !prev_flush_q};
    prev_flush_d = (if_id_mode == `Flush);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      prev_flush_q <= 1'b0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      prev_flush_q <= prev_flush_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-count model.
`ifndef Normal
`define Normal 2'b00
`endif
`ifndef Stall
`define Stall 2'b01
`endif
`ifndef Flush
`define Flush 2'b10
`endif
`ifndef Hazard_Signal_Width
`define Hazard_Signal_Width 4
`endif

module tb_pipeline_ctrl;
  localparam int TD = 3;
  localparam int HW = `Hazard_Signal_Width;
  localparam logic [1:0] N = `Normal, S = `Stall, F = `Flush;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hdu_if_stall, exe_redirect, mem_busy, trap_req;
  logic [1:0] hdu_if_id_mode, hdu_id_exe_mode;
  logic [HW-1:0] hdu_signal_cycle;
  logic pc_stall, trap_pc_load, ctrl_busy;
  logic [1:0] if_id_mode, id_exe_mode, exe_mem_mode, mem_wb_mode;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

  pipeline_ctrl #(.TRAP_DRAIN(TD), .HSW(HW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdu_if_id_mode(hdu_if_id_mode), .hdu_id_exe_mode(hdu_id_exe_mode),
    .hdu_if_stall(hdu_if_stall), .hdu_signal_cycle(hdu_signal_cycle),
    .exe_redirect(exe_redirect), .mem_busy(mem_busy), .trap_req(trap_req),
    .pc_stall(pc_stall), .if_id_mode(if_id_mode), .id_exe_mode(id_exe_mode),
    .exe_mem_mode(exe_mem_mode), .mem_wb_mode(mem_wb_mode),
    .trap_pc_load(trap_pc_load), .ctrl_busy(ctrl_busy)
`ifdef PIPELINE_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
`endif
  );

  int total = 0, bad = 0;

  // Model: remaining HOLD cycles, remaining drain cycles after the entry cycle,
  // a waiting flag, and pending pulses.
  int m_hold = 0, m_drain = 0, n_hold, n_drain;
  bit m_wait = 0, m_pr = 0, m_pt = 0, n_wait, n_pr, n_pt;
  logic [1:0] m_li = N, m_le = N, n_li, n_le;
  logic m_ls = 1'b0, n_ls;
  logic [10:0] exp_v;
  wire  [10:0] obs_v = {pc_stall, if_id_mode, id_exe_mode, exe_mem_mode, mem_wb_mode,
                        trap_pc_load, ctrl_busy};

  task automatic model_eval();
    logic ps, ld, cb;
    logic [1:0] a, b, c, d;
    bit tr, rd;
    ps = 0; ld = 0; a = N; b = N; c = N; d = N;
    cb = m_wait || (m_hold > 0) || (m_drain > 0);
    n_hold = m_hold; n_drain = m_drain; n_wait = m_wait; n_pr = m_pr; n_pt = m_pt;
    n_li = m_li; n_le = m_le; n_ls = m_ls;
    tr = trap_req || m_pt;
    rd = exe_redirect || m_pr;
    if (!rst_n) begin
      cb = 0; n_hold = 0; n_drain = 0; n_wait = 0; n_pr = 0; n_pt = 0;
    end else if (m_drain > 0) begin
      a = F; b = F; c = F;
      ps = (m_drain > 1); ld = (m_drain == 1);
      n_drain = m_drain - 1;
    end else if (mem_busy) begin
      ps = 1; a = S; b = S; c = S; d = F;
      n_wait = 1; n_pt = m_pt || trap_req; n_pr = m_pr || exe_redirect;
    end else begin
      n_wait = 0;
      if (tr) begin
        a = F; b = F; c = F; ps = 1;
        n_drain = TD; n_hold = 0; n_pt = 0; n_pr = 0;
      end else if (rd) begin
        a = F; b = F; n_hold = 0; n_pr = 0;
      end else if (m_hold > 0) begin
        a = m_li; b = m_le; ps = m_ls; n_hold = m_hold - 1;
      end else if (hdu_signal_cycle != 0) begin
        a = hdu_if_id_mode; b = hdu_id_exe_mode; ps = hdu_if_stall;
        if (hdu_signal_cycle > 1) begin
          n_li = hdu_if_id_mode; n_le = hdu_id_exe_mode; n_ls = hdu_if_stall;
          n_hold = int'(hdu_signal_cycle) - 1;
        end
      end
    end
    exp_v = {ps, a, b, c, d, ld, cb};
  endtask

  task automatic drive(input logic rs, input logic [1:0] im, input logic [1:0] em,
                       input logic st, input int sc, input logic rd, input logic mb,
                       input logic tr);
    rst_n = rs; hdu_if_id_mode = im; hdu_id_exe_mode = em; hdu_if_stall = st;
    hdu_signal_cycle = HW'(sc); exe_redirect = rd; mem_busy = mb; trap_req = tr;
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_hold = n_hold; m_drain = n_drain; m_wait = n_wait; m_pr = n_pr; m_pt = n_pt;
    m_li = n_li; m_le = n_le; m_ls = n_ls;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, F, F, 1, 3, 1, 1, 1);
      total++;
      if (obs_v !== exp_v || obs_v !== 11'b0_00_00_00_00_0_0) begin
        bad++; $display("FAIL reset got=%b want=%b", obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, S, F, 1, 1, 0, 0, 0);
      else        drive(1, N, N, 0, 0, 0, 0, 0);
      total++;
      if (obs_v !== exp_v || ctrl_busy !== 1'b0) begin
        bad++; $display("FAIL load_use c%0d got=%b want=%b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, S, F, 1, 3, 0, 0, 0);
      else        drive(1, N, N, 0, 0, 0, 0, 0);
      total++;
      if (obs_v !== exp_v || pc_stall !== (i < 3)) begin
        bad++; $display("FAIL hold c%0d got=%b want=%b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_mwait_redirect();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)     drive(1, S, S, 1, 3, 0, 0, 0);
      else if (i < 6) drive(1, N, N, 0, 0, (i == 3), (i >= 2), 0);
      else            drive(1, N, N, 0, 0, 0, 0, 0);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL mwait_redir c%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (i == 6) begin
        total++;
        if ({if_id_mode, id_exe_mode, pc_stall} !== {F, F, 1'b0}) begin
          bad++; $display("FAIL mwait_replay got=%b want=%b",
                          {if_id_mode, id_exe_mode, pc_stall}, {F, F, 1'b0});
        end
      end
      if (i == 7) begin
        total++;
        if (ctrl_busy !== 1'b0) begin
          bad++; $display("FAIL mwait_abort busy got=%b want=0", ctrl_busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_trap();
    for (int i = 0; i < 6; i++) begin
      drive(1, N, N, 0, 0, (i == 2), (i == 1), (i == 0));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL trap c%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (i == 3) begin
        total++;
        if ({trap_pc_load, pc_stall, if_id_mode} !== {1'b1, 1'b0, F}) begin
          bad++; $display("FAIL trap_load got=%b want=%b",
                          {trap_pc_load, pc_stall, if_id_mode}, {1'b1, 1'b0, F});
        end
      end
      tick();
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1, S, F, 1, 3, 1, 0, 1);
      else        drive(1, N, N, 0, 0, 0, 0, 0);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL same_cycle c%0d got=%b want=%b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 5; i++) begin
      drive((i != 2), N, N, 0, 0, 0, 0, (i == 0));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL rst_drain c%0d got=%b want=%b", i, obs_v, exp_v);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      if (i == 3) begin
        total++;
        if (perf_stall_cycles !== 32'd0 || perf_flush_events !== 32'd0) begin
          bad++; $display("FAIL perf_rst got=%0d/%0d want=0/0",
                          perf_stall_cycles, perf_flush_events);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) != 0), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
            1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 24) == 0));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random c%0d got=%b want=%b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hold();
    test_mwait_redirect();
    test_trap();
    test_same_cycle();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
